// File: rtl/ll_monitor_pkg.sv
// Shared CPU definitions for the LL/SC reservation monitor.
package ll_monitor_pkg;

    // Global issue width of the memory stage.
    localparam int unsigned CPU_ISSUE_NUM = 2;

    // Per-lane memory operation class seen by the reservation monitor.
    typedef enum logic [1:0] {
        LLSC_NONE = 2'd0,
        LLSC_LL   = 2'd1,
        LLSC_SC   = 2'd2,
        LLSC_ST   = 2'd3
    } llsc_op_t;

    // Reservation FSM state.
    typedef enum logic {
        LL_IDLE     = 1'b0,
        LL_RESERVED = 1'b1
    } ll_state_t;

endpackage

// File: rtl/ll_monitor_lane_eval.sv
// Combinational evaluation of one memory lane against the reservation
// state left by older lanes in the same cycle.
import ll_monitor_pkg::*;

module llsc_lane_eval #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned GRANULE_BITS      = 4,
    parameter bit          CLEAR_ON_LOCAL_ST = 1'b0
) (
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  ll_in,
    input  llsc_op_t              op,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  valid_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  ll_out,
    output logic                  sc_success
);

    localparam logic [ADDR_WIDTH-1:0] GRAN_MASK = {ADDR_WIDTH{1'b1}} << GRANULE_BITS;

    logic [ADDR_WIDTH-1:0] gaddr;
    logic                  match;

    assign gaddr = addr & GRAN_MASK;
    assign match = (gaddr == addr_in);

    // Apply this lane's op to the incoming reservation state.
    always_comb begin
        valid_out  = valid_in;
        addr_out   = addr_in;
        ll_out     = ll_in;
        sc_success = 1'b0;
        unique case (op)
            LLSC_LL: begin
                valid_out = 1'b1;
                addr_out  = gaddr;
                ll_out    = 1'b1;
            end
            LLSC_SC: begin
                sc_success = valid_in && match;
                valid_out  = 1'b0;
            end
            LLSC_ST: begin
                if (CLEAR_ON_LOCAL_ST && match) valid_out = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ll_monitor.sv
// LL/SC reservation monitor: one reservation shared by all memory lanes,
// cleared by SC, snoops, exceptions, optional local stores and timeout.
import ll_monitor_pkg::*;

module ll_monitor #(
    parameter int unsigned ISSUE_NUM         = CPU_ISSUE_NUM,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned GRANULE_BITS      = 4,
    parameter int unsigned TIMEOUT           = 0,
    parameter bit          CLEAR_ON_LOCAL_ST = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 except_valid,
    input  llsc_op_t [ISSUE_NUM-1:0]             lane_op,
    input  logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] lane_addr,
    input  logic                                 snoop_valid,
    input  logic [ADDR_WIDTH-1:0]                snoop_addr,
    output logic [ISSUE_NUM-1:0]                 sc_success,
    output logic                                 link_valid,
    output logic [ADDR_WIDTH-1:0]                link_addr
);

    localparam int unsigned AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] GRAN_MASK = {ADDR_WIDTH{1'b1}} << GRANULE_BITS;

    ll_state_t             state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [AGE_W-1:0]      age_q;

    logic                  valid_c [0:ISSUE_NUM];
    logic [ADDR_WIDTH-1:0] addr_c  [0:ISSUE_NUM];
    logic                  ll_c    [0:ISSUE_NUM];
    logic [ISSUE_NUM-1:0]  sc_raw;

    logic                  valid_d;
    logic                  snoop_hit;
    logic                  expire;

    assign valid_c[0] = (state == LL_RESERVED);
    assign addr_c[0]  = addr_q;
    assign ll_c[0]    = 1'b0;

    for (genvar i = 0; i < ISSUE_NUM; i++) begin : g_lane
        llsc_lane_eval #(
            .ADDR_WIDTH       (ADDR_WIDTH),
            .GRANULE_BITS     (GRANULE_BITS),
            .CLEAR_ON_LOCAL_ST(CLEAR_ON_LOCAL_ST)
        ) u_eval (
            .valid_in  (valid_c[i]),
            .addr_in   (addr_c[i]),
            .ll_in     (ll_c[i]),
            .op        (lane_op[i]),
            .addr      (lane_addr[i]),
            .valid_out (valid_c[i+1]),
            .addr_out  (addr_c[i+1]),
            .ll_out    (ll_c[i+1]),
            .sc_success(sc_raw[i])
        );
    end

    // Snoop, timeout and exception are applied after the whole lane chain.
    always_comb begin
        snoop_hit = snoop_valid && ((snoop_addr & GRAN_MASK) == addr_c[ISSUE_NUM]);
        expire    = (TIMEOUT > 0) && (state == LL_RESERVED) &&
                    (age_q == AGE_LAST) && !ll_c[ISSUE_NUM];
        valid_d   = valid_c[ISSUE_NUM] && !snoop_hit && !expire && !except_valid;
    end

    assign link_valid = rst_n && valid_d;
    assign sc_success = (rst_n && !except_valid) ? sc_raw : '0;
    assign link_addr  = addr_q;

    // Reservation FSM with address register and saturating age counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LL_IDLE;
            addr_q <= '0;
            age_q  <= '0;
        end else begin
            state <= valid_d ? LL_RESERVED : LL_IDLE;
            if (!except_valid) addr_q <= addr_c[ISSUE_NUM];
            if (!valid_d || ll_c[ISSUE_NUM]) begin
                age_q <= '0;
            end else if ((TIMEOUT > 0) && (age_q != AGE_MAX)) begin
                age_q <= age_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ll_monitor.sv
// Directed self-checking bench for ll_monitor: a default instance and a
// TIMEOUT=8 / CLEAR_ON_LOCAL_ST=1 instance share the same stimulus.
import ll_monitor_pkg::*;

module tb_ll_monitor;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                except_valid;
    llsc_op_t [1:0]      lane_op;
    logic [1:0][31:0]    lane_addr;
    logic                snoop_valid;
    logic [31:0]         snoop_addr;
    logic [1:0]          sc_a, sc_b;
    logic                lv_a, lv_b;
    logic [31:0]         la_a, la_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    ll_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .except_valid(except_valid),
        .lane_op(lane_op), .lane_addr(lane_addr),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .sc_success(sc_a), .link_valid(lv_a), .link_addr(la_a)
    );

    ll_monitor #(.TIMEOUT(8), .CLEAR_ON_LOCAL_ST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .except_valid(except_valid),
        .lane_op(lane_op), .lane_addr(lane_addr),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .sc_success(sc_b), .link_valid(lv_b), .link_addr(la_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Set up one cycle of stimulus, then settle combinational outputs.
    task automatic drive(input llsc_op_t op0, input logic [31:0] a0,
                         input llsc_op_t op1, input logic [31:0] a1,
                         input logic sv, input logic [31:0] sa, input logic ex);
        lane_op[0]   = op0;
        lane_addr[0] = a0;
        lane_op[1]   = op1;
        lane_addr[1] = a1;
        snoop_valid  = sv;
        snoop_addr   = sa;
        except_valid = ex;
        #2;
    endtask

    task automatic idle();
        drive(LLSC_NONE, 0, LLSC_NONE, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        // LL presented during reset must not become visible.
        drive(LLSC_LL, 32'h1000, LLSC_SC, 32'h1000, 1'b0, 0, 1'b0);
        check("rst_link_valid", lv_a, 0);
        check("rst_sc", sc_a, 0);
        check("rst_link_addr", la_a, 0);
        tick();
        check("rst_hold_addr", la_a, 0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // LL then SC two cycles later on a different word in the granule.
        drive(LLSC_LL, 32'h1004, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("ll_link_valid", lv_a, 1);
        tick();
        check("ll_link_addr", la_a, 32'h1000);
        idle();
        check("ll_hold", lv_a, 1);
        tick();
        drive(LLSC_SC, 32'h100C, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("sc_ok", sc_a, 2'b01);
        check("sc_clears", lv_a, 0);
        tick();
        idle();
        check("after_sc_idle", lv_a, 0);

        // Same-cycle LL in lane 0 and SC in lane 1.
        drive(LLSC_LL, 32'h2000, LLSC_SC, 32'h2008, 1'b0, 0, 1'b0);
        check("same_cycle_sc", sc_a, 2'b10);
        check("same_cycle_lv", lv_a, 0);
        tick();
        drive(LLSC_SC, 32'h2000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("sc_no_resv", sc_a, 0);
        tick();

        // Snoop ordering after lanes.
        drive(LLSC_LL, 32'h3000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        drive(LLSC_SC, 32'h3000, LLSC_NONE, 0, 1'b1, 32'h3004, 1'b0);
        check("sc_with_snoop", sc_a, 2'b01);
        tick();
        drive(LLSC_LL, 32'h3000, LLSC_NONE, 0, 1'b1, 32'h3000, 1'b0);
        check("ll_with_snoop", lv_a, 0);
        tick();
        drive(LLSC_SC, 32'h3000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("sc_after_snoop", sc_a, 0);
        tick();
        drive(LLSC_LL, 32'h3000, LLSC_NONE, 0, 1'b1, 32'h3010, 1'b0);
        check("snoop_other_granule", lv_a, 1);
        tick();

        // Granule mismatch and younger LL override.
        drive(LLSC_LL, 32'h6000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        drive(LLSC_SC, 32'h6010, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("sc_mismatch", sc_a, 0);
        tick();
        drive(LLSC_LL, 32'h7000, LLSC_LL, 32'h710F, 1'b0, 0, 1'b0);
        tick();
        check("younger_ll_addr", la_a, 32'h7100);
        drive(LLSC_SC, 32'h7000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("older_ll_lost", sc_a, 0);
        tick();

        // Exception overrides SC.
        drive(LLSC_LL, 32'h4000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        drive(LLSC_SC, 32'h4000, LLSC_NONE, 0, 1'b0, 0, 1'b1);
        check("except_sc", sc_a, 0);
        check("except_lv", lv_a, 0);
        tick();

        // Local store: ignored by default, clears when enabled.
        drive(LLSC_LL, 32'h8000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        drive(LLSC_ST, 32'h8008, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("st_ignored", lv_a, 1);
        check("st_clears", lv_b, 0);
        tick();
        drive(LLSC_SC, 32'h8000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("sc_after_st_a", sc_a, 2'b01);
        check("sc_after_st_b", sc_b, 0);
        tick();

        // Timeout: SC seven cycles after LL still succeeds.
        drive(LLSC_LL, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        for (int i = 1; i < 7; i++) begin
            idle();
            tick();
        end
        drive(LLSC_SC, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("timeout_sc7", sc_b, 2'b01);
        tick();

        // Timeout: after eight idle cycles the reservation has expired.
        drive(LLSC_LL, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        for (int i = 1; i < 8; i++) begin
            idle();
            tick();
        end
        idle();
        check("timeout_expire_lv", lv_b, 0);
        check("no_timeout_lv", lv_a, 1);
        tick();
        drive(LLSC_SC, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("timeout_sc9", sc_b, 0);
        check("no_timeout_sc9", sc_a, 2'b01);
        tick();

        // Reset while reserved discards the reservation.
        drive(LLSC_LL, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_lv", lv_a, 0);
        check("midrst_addr", la_a, 0);
        tick();
        rst_n = 1'b1;
        drive(LLSC_SC, 32'h5000, LLSC_NONE, 0, 1'b0, 0, 1'b0);
        check("postrst_sc", sc_a, 0);
        check("postrst_addr", la_a, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
